// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//   Instruction-fetch stage plus the IF/ID pipeline register that feeds
//   decode. Holds the PC, picks the next PC (sequential, branch or jump),
//   and fetches through a req/ack instruction-memory port of variable
//   latency. A word that arrives while decode is stalled is parked in a
//   hold buffer; a redirect that arrives while a request is still
//   outstanding waits for that request to finish before the new fetch
//   starts.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   pcLd, IFtoIDld     PC advance enable, IF/ID load enable
//   flush              load a bubble into IF/ID (only when pcLd=1)
//   pcSrc              00 seq, 01 branchAddress, 10 jAddress, 11 seq
//   branchAddress      branch target
//   jAddress           jump target
//   imem_req/addr      fetch request and address (address held until ack)
//   imem_ack/rdata     fetch completion and instruction word
//   instruction        IF/ID instruction word
//   pcAdded            IF/ID fetch PC + 4
//   if_valid           IF/ID holds a real instruction
//   perf_fetched       (IF_PERF_CNT_EN) count of valid IF/ID loads
//   perf_bubbles       (IF_PERF_CNT_EN) count of bubble IF/ID loads
//
// Build option
//   IF_PERF_CNT_EN     adds the two wrapping 32-bit performance counters.
// ---------------------------------------------------------------------------
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pcLd,
    input  logic        IFtoIDld,
    input  logic        flush,
    input  logic [1:0]  pcSrc,
    input  logic [31:0] branchAddress,
    input  logic [31:0] jAddress,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] pcAdded,
    output logic        if_valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_bubbles
`endif
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_HOLD,
        S_DRAIN
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] redir_q, redir_d;
    logic        req_q, req_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcadd_q, pcadd_d;
    logic        valid_q, valid_d;

    logic        advance, redirect, ack, deliver, load_valid, load_bubble;
    logic [31:0] target, word, pc_plus4;

    assign advance  = pcLd & IFtoIDld;
    assign redirect = pcLd & ((pcSrc == 2'b01) | (pcSrc == 2'b10));
    assign target   = (pcSrc == 2'b10) ? jAddress : branchAddress;
    assign pc_plus4 = pc_q + 32'd4;
    // ack only counts while a request is actually being presented
    assign ack      = imem_ack & imem_req;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        hold_d  = hold_q;
        redir_d = redir_q;
        deliver = 1'b0;
        word    = imem_rdata;
        unique case (state_q)
            S_FETCH: begin
                if (ack) begin
                    if (redirect) begin
                        pc_d = target;
                    end else if (advance) begin
                        deliver = 1'b1;
                        pc_d    = pc_plus4;
                    end else begin
                        hold_d  = imem_rdata;
                        state_d = S_HOLD;
                    end
                end else if (redirect) begin
                    redir_d = target;
                    state_d = S_DRAIN;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_d    = target;
                    state_d = S_FETCH;
                end else if (advance) begin
                    deliver = 1'b1;
                    word    = hold_q;
                    pc_d    = pc_plus4;
                    state_d = S_FETCH;
                end
            end
            S_DRAIN: begin
                // A redirect in the ack cycle itself is the latest one, so it
                // takes precedence over the stored target.
                if (redirect) redir_d = target;
                if (ack) begin
                    pc_d    = redirect ? target : redir_q;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase

        req_d = (state_d != S_HOLD);

        load_valid  = IFtoIDld & deliver & ~(flush & pcLd);
        load_bubble = IFtoIDld & ~load_valid;

        instr_d = instr_q;
        pcadd_d = pcadd_q;
        valid_d = valid_q;
        if (load_valid) begin
            instr_d = word;
            pcadd_d = pc_plus4;
            valid_d = 1'b1;
        end else if (load_bubble) begin
            instr_d = NOP_WORD;
            pcadd_d = '0;
            valid_d = 1'b0;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetched_q, bubbles_q;
    assign perf_fetched = fetched_q;
    assign perf_bubbles = bubbles_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            hold_q  <= '0;
            redir_q <= '0;
            req_q   <= 1'b1;
            instr_q <= NOP_WORD;
            pcadd_q <= '0;
            valid_q <= 1'b0;
`ifdef IF_PERF_CNT_EN
            fetched_q <= '0;
            bubbles_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hold_q  <= hold_d;
            redir_q <= redir_d;
            req_q   <= req_d;
            instr_q <= instr_d;
            pcadd_q <= pcadd_d;
            valid_q <= valid_d;
`ifdef IF_PERF_CNT_EN
            if (load_valid)  fetched_q <= fetched_q + 32'd1;
            if (load_bubble) bubbles_q <= bubbles_q + 32'd1;
`endif
        end
    end

    // Request is forced low during reset so an outstanding fetch is abandoned.
    assign imem_req    = req_q & ~rst;
    // pc_q is not updated until ack in FETCH/DRAIN, so it is the held address.
    assign imem_addr   = pc_q;
    assign instruction = instr_q;
    assign pcAdded     = pcadd_q;
    assign if_valid    = valid_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_stage
//   Directed bench for if_fetch_stage. The instruction memory returns its
//   address as data and acknowledges 'lat' cycles after a request starts.
//   Inputs change on the falling edge; outputs are checked on the falling
//   edge after each rising edge.
// ---------------------------------------------------------------------------
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst, pcLd, IFtoIDld, flush;
    logic [1:0]  pcSrc;
    logic [31:0] branchAddress, jAddress;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] instruction, pcAdded;
    logic        if_valid;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_bubbles;
`endif

    int unsigned lat;
    int unsigned cnt;
    int checks   = 0;
    int failures = 0;

    if_fetch_stage #(
        .RESET_PC(32'h0000_0000),
        .NOP_WORD(32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pcLd         (pcLd),
        .IFtoIDld     (IFtoIDld),
        .flush        (flush),
        .pcSrc        (pcSrc),
        .branchAddress(branchAddress),
        .jAddress     (jAddress),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instruction  (instruction),
        .pcAdded      (pcAdded),
        .if_valid     (if_valid)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_bubbles (perf_bubbles)
`endif
    );

    always #5 clk = ~clk;

    // Memory: counts cycles of the current request, acks once lat reached.
    always @(posedge clk) begin
        if (!imem_req || imem_ack) cnt <= 0;
        else                       cnt <= cnt + 1;
    end
    assign imem_ack   = imem_req && (cnt >= lat);
    assign imem_rdata = imem_addr;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        cnt = 0;
        rst = 1'b1; pcLd = 1'b1; IFtoIDld = 1'b1; flush = 1'b0;
        pcSrc = 2'b00; branchAddress = '0; jAddress = '0; lat = 0;

        // 1: zero-wait memory, one instruction per cycle
        tick();
        check("rst_req",   {31'd0, imem_req}, 32'd0);
        check("rst_instr", instruction,       32'd0);
        check("rst_pcadd", pcAdded,           32'd0);
        check("rst_valid", {31'd0, if_valid}, 32'd0);
        rst = 1'b0; #1;
        check("s1_req",    {31'd0, imem_req}, 32'd1);
        check("s1_addr0",  imem_addr,         32'h0);
        tick();
        check("s1_instr0", instruction,       32'h0);
        check("s1_pcadd0", pcAdded,           32'h4);
        check("s1_valid0", {31'd0, if_valid}, 32'd1);
        check("s1_addr4",  imem_addr,         32'h4);
        tick();
        check("s1_instr4", instruction,       32'h4);
        check("s1_pcadd4", pcAdded,           32'h8);
        check("s1_addr8",  imem_addr,         32'h8);

        // 2: two-cycle latency gives two bubbles then the word at 0
        rst = 1'b1; lat = 2;
        tick();
        rst = 1'b0;
        tick();
        check("s2_bub1_valid", {31'd0, if_valid}, 32'd0);
        check("s2_bub1_addr",  imem_addr,         32'h0);
        tick();
        check("s2_bub2_valid", {31'd0, if_valid}, 32'd0);
        check("s2_bub2_instr", instruction,       32'h0);
        tick();
        check("s2_word_valid", {31'd0, if_valid}, 32'd1);
        check("s2_word_instr", instruction,       32'h0);
        check("s2_word_pcadd", pcAdded,           32'h4);
`ifdef IF_PERF_CNT_EN
        check("s2_perf_fetched", perf_fetched, 32'd1);
        check("s2_perf_bubbles", perf_bubbles, 32'd2);
`endif

        // 3: stall in the ack cycle parks the word in HOLD
        rst = 1'b1; lat = 0;
        tick();
        rst = 1'b0;
        tick();
        pcLd = 1'b0; IFtoIDld = 1'b0;
        tick();
        check("s3_hold_req",   {31'd0, imem_req}, 32'd0);
        check("s3_hold_pcadd", pcAdded,           32'h4);
        check("s3_hold_valid", {31'd0, if_valid}, 32'd1);
        tick();
        check("s3_hold2_req",  {31'd0, imem_req}, 32'd0);
        check("s3_hold2_instr", instruction,      32'h0);
        check("s3_hold2_pcadd", pcAdded,          32'h4);
        pcLd = 1'b1; IFtoIDld = 1'b1;
        tick();
        check("s3_rel_instr", instruction,       32'h4);
        check("s3_rel_pcadd", pcAdded,           32'h8);
        check("s3_rel_valid", {31'd0, if_valid}, 32'd1);
        check("s3_rel_addr",  imem_addr,         32'h8);
        check("s3_rel_req",   {31'd0, imem_req}, 32'd1);

        // 4: branch while request at 8 is pending -> drain, then 0x40
        lat = 2; pcSrc = 2'b01; branchAddress = 32'h40;
        tick();
        pcSrc = 2'b00; branchAddress = '0;
        check("s4_drain_addr",  imem_addr,         32'h8);
        check("s4_drain_req",   {31'd0, imem_req}, 32'd1);
        check("s4_drain_valid", {31'd0, if_valid}, 32'd0);
        tick();
        check("s4_drain2_addr", imem_addr,         32'h8);
        tick();
        check("s4_tgt_addr",    imem_addr,         32'h40);
        check("s4_tgt_valid",   {31'd0, if_valid}, 32'd0);
        lat = 0;
        tick();
        check("s4_tgt_instr",   instruction,       32'h40);
        check("s4_tgt_pcadd",   pcAdded,           32'h44);
        check("s4_next_addr",   imem_addr,         32'h44);

        // 5: jump + flush in ack cycle; then same with pcLd=0 (ignored)
        pcSrc = 2'b10; jAddress = 32'h100; flush = 1'b1;
        tick();
        check("s5_flush_valid", {31'd0, if_valid}, 32'd0);
        check("s5_flush_instr", instruction,       32'h0);
        check("s5_jump_addr",   imem_addr,         32'h100);
        pcLd = 1'b0; jAddress = 32'h200;
        tick();
        check("s5_nold_req",    {31'd0, imem_req}, 32'd0);
        check("s5_nold_valid",  {31'd0, if_valid}, 32'd0);
        pcLd = 1'b1; pcSrc = 2'b00; flush = 1'b0;
        tick();
        check("s5_seq_instr",   instruction,       32'h100);
        check("s5_seq_pcadd",   pcAdded,           32'h104);
        check("s5_seq_addr",    imem_addr,         32'h104);

        // PC wraps modulo 2^32
        pcSrc = 2'b01; branchAddress = 32'hFFFF_FFFC;
        tick();
        pcSrc = 2'b00;
        check("wrap_tgt_addr",  imem_addr,         32'hFFFF_FFFC);
        tick();
        check("wrap_instr",     instruction,       32'hFFFF_FFFC);
        check("wrap_pcadd",     pcAdded,           32'h0);
        check("wrap_addr",      imem_addr,         32'h0);

        // 6: reset while in HOLD
        pcLd = 1'b0; IFtoIDld = 1'b0;
        tick();
        check("s6_hold_req",    {31'd0, imem_req}, 32'd0);
        rst = 1'b1; pcLd = 1'b1; IFtoIDld = 1'b1;
        tick();
        check("s6_rst_req",     {31'd0, imem_req}, 32'd0);
        check("s6_rst_valid",   {31'd0, if_valid}, 32'd0);
        check("s6_rst_instr",   instruction,       32'h0);
        rst = 1'b0; #1;
        check("s6_fetch_req",   {31'd0, imem_req}, 32'd1);
        check("s6_fetch_addr",  imem_addr,         32'h0);
        tick();
        check("s6_first_valid", {31'd0, if_valid}, 32'd1);
        check("s6_first_pcadd", pcAdded,           32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
